// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator.
// Holds the default 15 kHz timing constants, the raster state record and a
// small window-compare helper used for the sync flags.
package video_timing_pkg;

  // Width of the horizontal and vertical counters.
  localparam int unsigned CNT_W = 9;

  // Default timing (320x240 visible, 384 pixels per line).
  localparam int unsigned DEF_CE_DIV        = 8;
  localparam int unsigned DEF_H_TOTAL       = 384;
  localparam int unsigned DEF_H_ACTIVE      = 320;
  localparam int unsigned DEF_HS_START      = 336;
  localparam int unsigned DEF_HS_END        = 368;
  localparam int unsigned DEF_V_ACTIVE      = 240;
  localparam int unsigned DEF_NTSC_VTOTAL   = 262;
  localparam int unsigned DEF_PAL_VTOTAL    = 312;
  localparam int unsigned DEF_NTSC_VS_START = 244;
  localparam int unsigned DEF_PAL_VS_START  = 270;
  localparam int unsigned DEF_VS_LINES      = 3;

  // Raster position plus the flags describing that position.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblank;
    logic             vblank;
    logic             hsync;
    logic             vsync;
  } raster_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_ce_divider.sv
// Programmable divide-by-N pulse generator.
// Counts 0..N-1 where N = DIV, or DIV/2 when half_i is set.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   half_i  - select half-rate divide (DIV/2)
//   tick_o  - combinational: high on the clock the count is at N-1
//   ce_o    - registered one-clock pulse, high in the cycle after tick_o
module ce_divider #(
  parameter int unsigned DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic half_i,
  output logic tick_o,
  output logic ce_o
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'((DIV / 2) - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] last_s;

  // Terminal-count detect and next count value.
  always_comb begin
    last_s = half_i ? LAST_HALF : LAST_FULL;
    // >= keeps the counter from running away should it ever sit above the
    // half-rate terminal value.
    tick_o = (cnt_q >= last_s);
    if (tick_o) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register and registered enable pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CW{1'b0}};
      ce_o  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_o  <= tick_o;
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator for the emu core video path.
// Produces the pixel enable, hcount/vcount and blank/sync flags. NTSC/PAL
// line count and the 31 kHz scandoubled mode are latched at frame start.
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   pal, scandouble       - mode requests, sampled when the raster wraps
//   ce_pix                - one-clock pixel enable
//   hcount, vcount        - current pixel column / source line
//   HBlank, VBlank        - blanking flags
//   HSync, VSync          - active-high sync flags
//   frame_start           - pulse coincident with ce_pix at (0,0)
//   field                 - toggles every frame
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned CE_DIV        = DEF_CE_DIV,
  parameter int unsigned H_TOTAL       = DEF_H_TOTAL,
  parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
  parameter int unsigned HS_START      = DEF_HS_START,
  parameter int unsigned HS_END        = DEF_HS_END,
  parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
  parameter int unsigned NTSC_VTOTAL   = DEF_NTSC_VTOTAL,
  parameter int unsigned PAL_VTOTAL    = DEF_PAL_VTOTAL,
  parameter int unsigned NTSC_VS_START = DEF_NTSC_VS_START,
  parameter int unsigned PAL_VS_START  = DEF_PAL_VS_START,
  parameter int unsigned VS_LINES      = DEF_VS_LINES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pal,
  input  logic             scandouble,
  output logic             ce_pix,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             HBlank,
  output logic             VBlank,
  output logic             HSync,
  output logic             VSync,
  output logic             frame_start,
  output logic             field
);

  if ((H_TOTAL > 511) || (H_ACTIVE > 511) || (HS_START > 511) ||
      (HS_END > 511) || (V_ACTIVE > 511) || (NTSC_VTOTAL > 511) ||
      (PAL_VTOTAL > 511) || (NTSC_VS_START > 511) || (PAL_VS_START > 511) ||
      (VS_LINES > 511) || (CE_DIV < 4) || ((CE_DIV % 2) != 0)) begin : g_bad_param
    $error("video_timing: illegal timing parameter");
  end

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT        = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO        = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_HI        = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] V_ACT        = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] NTSC_VT_LAST = CNT_W'(NTSC_VTOTAL - 1);
  localparam logic [CNT_W-1:0] PAL_VT_LAST  = CNT_W'(PAL_VTOTAL - 1);
  localparam logic [CNT_W-1:0] NTSC_VS      = CNT_W'(NTSC_VS_START);
  localparam logic [CNT_W-1:0] PAL_VS       = CNT_W'(PAL_VS_START);
  localparam logic [CNT_W-1:0] VS_LEN       = CNT_W'(VS_LINES);

  raster_t          raster_q;
  raster_t          raster_d;
  logic             rep_q;
  logic             rep_d;
  logic             pal_l_q;
  logic             sd_l_q;
  logic             frame_start_q;
  logic             field_q;
  logic             tick_s;
  logic             h_last_s;
  logic             v_inc_s;
  logic             frame_wrap_s;
  logic [CNT_W-1:0] vt_last_s;
  logic [CNT_W-1:0] vs_start_s;
  logic [CNT_W-1:0] vs_end_s;

  // The divider runs at half the period once the frame latches scandouble,
  // which keeps the frame length in clocks identical in both modes.
  ce_divider #(
    .DIV (CE_DIV)
  ) u_ce_divider (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .half_i (sd_l_q),
    .tick_o (tick_s),
    .ce_o   (ce_pix)
  );

  // Next raster position and the flags for that position.
  always_comb begin
    vt_last_s  = pal_l_q ? PAL_VT_LAST : NTSC_VT_LAST;
    vs_start_s = pal_l_q ? PAL_VS : NTSC_VS;
    vs_end_s   = vs_start_s + VS_LEN;
    h_last_s   = (raster_q.hcount == H_LAST);
    rep_d      = rep_q;
    v_inc_s    = 1'b0;
    if (h_last_s) begin
      if (sd_l_q) begin
        // Each source line is emitted twice; vcount moves on the 1->0 edge.
        rep_d   = ~rep_q;
        v_inc_s = rep_q;
      end else begin
        v_inc_s = 1'b1;
      end
    end else begin
      rep_d = rep_q;
    end
    frame_wrap_s = v_inc_s && (raster_q.vcount == vt_last_s);

    raster_d = raster_q;
    if (h_last_s) begin
      raster_d.hcount = {CNT_W{1'b0}};
    end else begin
      raster_d.hcount = raster_q.hcount + CNT_W'(1);
    end
    if (frame_wrap_s) begin
      raster_d.vcount = {CNT_W{1'b0}};
    end else if (v_inc_s) begin
      raster_d.vcount = raster_q.vcount + CNT_W'(1);
    end else begin
      raster_d.vcount = raster_q.vcount;
    end
    raster_d.hblank = (raster_d.hcount >= H_ACT);
    raster_d.hsync  = in_window(raster_d.hcount, HS_LO, HS_HI);
    raster_d.vblank = (raster_d.vcount >= V_ACT);
    raster_d.vsync  = in_window(raster_d.vcount, vs_start_s, vs_end_s);
  end

  // Raster state; advances only on the divider terminal count so outputs
  // change together with the registered ce_pix pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raster_q      <= '0;
      rep_q         <= 1'b0;
      pal_l_q       <= 1'b0;
      sd_l_q        <= 1'b0;
      frame_start_q <= 1'b0;
      field_q       <= 1'b0;
    end else if (tick_s) begin
      raster_q      <= raster_d;
      rep_q         <= rep_d;
      frame_start_q <= frame_wrap_s;
      if (frame_wrap_s) begin
        field_q <= ~field_q;
        pal_l_q <= pal;
        sd_l_q  <= scandouble;
      end
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign hcount      = raster_q.hcount;
  assign vcount      = raster_q.vcount;
  assign HBlank      = raster_q.hblank;
  assign VBlank      = raster_q.vblank;
  assign HSync       = raster_q.hsync;
  assign VSync       = raster_q.vsync;
  assign frame_start = frame_start_q;
  assign field       = field_q;

endmodule
